// File: rtl/forward_scoreboard.sv
// In-flight destination tracker: selects the nearest bypass stage per
// source operand and raises load-use and HI/LO multiply stalls.
module forward_scoreboard #(
  parameter  int NUM_SRC = 2,
  parameter  int DEPTH   = 3,
  parameter  int ADDR_W  = 6,
  parameter  int MUL_LAT = 4,
  localparam int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      issue_valid,
  input  logic                      issue_regwrite,
  input  logic [ADDR_W-1:0]         issue_dst,
  input  logic                      issue_is_load,
  input  logic                      issue_is_mult,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic                      mult_busy
);

  localparam int MW = $clog2(MUL_LAT + 1);
  localparam logic [ADDR_W-1:0] HI   = ADDR_W'(32);
  localparam logic [ADDR_W-1:0] LO   = ADDR_W'(33);
  localparam logic [ADDR_W-1:0] PAIR = ADDR_W'(34);

  logic [DEPTH:1]             ent_v;
  logic [DEPTH:1]             ent_ld;
  logic [DEPTH:1][ADDR_W-1:0] ent_dst;
  logic [MW-1:0]              mcnt;

  logic                       busy;
  logic                       stall_raw;
  logic                       ins;
  logic                       mult_go;
  logic [NUM_SRC*SEL_W-1:0]   sel_d;

  assign busy = (mcnt != '0);

  always_comb begin
    logic [ADDR_W-1:0] src;
    logic [SEL_W-1:0]  sel;
    logic              hit_ld;
    stall_raw = issue_valid & issue_is_mult & busy;
    sel_d     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src    = src_addr[i*ADDR_W +: ADDR_W];
      sel    = '0;
      hit_ld = 1'b0;
      // scan oldest to youngest so the nearest match is left standing
      for (int k = DEPTH; k >= 1; k--) begin
        if (src != '0 && ent_v[k] &&
            (ent_dst[k] == src ||
             (ent_dst[k] == PAIR && (src == HI || src == LO)))) begin
          sel    = SEL_W'(k);
          hit_ld = ent_ld[k] && (k == 1);
        end
      end
      if (hit_ld)
        stall_raw = 1'b1;
      if (busy && (src == HI || src == LO || src == PAIR))
        stall_raw = 1'b1;
      sel_d[i*SEL_W +: SEL_W] = sel;
    end
  end

  assign fwd_sel   = rst ? '0 : sel_d;
  assign stall     = rst ? 1'b0 : stall_raw;
  assign mult_busy = rst ? 1'b0 : busy;

  assign mult_go = issue_valid & issue_is_mult & ~stall_raw & ~flush;
  assign ins     = issue_valid & issue_regwrite & ~issue_is_mult &
                   ~stall_raw & ~flush & (issue_dst != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      ent_v  <= '0;
      ent_ld <= '0;
      mcnt   <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        ent_v[k]  <= ent_v[k-1];
        ent_ld[k] <= ent_ld[k-1];
      end
      ent_v[1]  <= ins;
      ent_ld[1] <= ins & issue_is_load;
      if (mult_go)
        mcnt <= MW'(MUL_LAT);
      else if (busy)
        mcnt <= mcnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = DEPTH; k >= 2; k--)
      ent_dst[k] <= ent_dst[k-1];
    ent_dst[1] <= issue_dst;
  end

endmodule
